// File: rtl/bloco_defuzzificador.sv
// Nie-Tan type reduction and defuzzification: accumulates rule firing intervals and divides
// sum((F_LOW+F_UP)*C) by sum(F_LOW+F_UP) with a bit-serial restoring divider.
module bloco_defuzzificador #(
    parameter int unsigned W          = 8,
    parameter int unsigned MAX_REGRAS = 16,
    parameter int unsigned NUM_W      = 2 * W + 1 + $clog2(MAX_REGRAS),
    parameter int unsigned DEN_W      = W + 1 + $clog2(MAX_REGRAS)
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         Regra_Valid,
    input  logic         Regra_Last,
    input  logic [W-1:0] F_LOW,
    input  logic [W-1:0] F_UP,
    input  logic [W-1:0] Centroide,
    output logic         Pronto,
    output logic [W-1:0] Saida,
    output logic         Saida_Valid,
    output logic         Div_Zero,
    output logic         Ocupado
);

    localparam int unsigned CNT_W = $clog2(MAX_REGRAS) + 1;
    localparam int unsigned DC_W  = $clog2(NUM_W);

    typedef enum logic [1:0] {StOcioso, StAcumula, StDivide, StSaida} estado_e;

    estado_e estado_q, estado_d;

    logic [NUM_W-1:0] num_q;
    logic [DEN_W-1:0] den_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DEN_W-1:0] rem_q;
    logic [W-1:0]     quo_q;
    logic [DC_W-1:0]  div_cnt_q;
    logic [W-1:0]     saida_q;
    logic             div_zero_q;

    logic             aceita;
    logic             ultimo;
    logic             den_zero;
    logic             div_fim;
    logic [W:0]       soma;
    logic [NUM_W-1:0] prod;
    logic [CNT_W-1:0] cnt_base;
    logic [DEN_W:0]   rem_desl;
    logic             q_bit;
    logic [DEN_W-1:0] rem_prox;

    assign soma     = {1'b0, F_LOW} + {1'b0, F_UP};
    assign prod     = NUM_W'(soma) * NUM_W'(Centroide);
    // A frame's first beat starts from zero regardless of what the registers still hold.
    assign cnt_base = (estado_q == StOcioso) ? '0 : cnt_q;
    assign aceita   = Regra_Valid && Pronto;
    assign ultimo   = Regra_Last || (cnt_base == CNT_W'(MAX_REGRAS - 1));
    assign den_zero = (den_q == '0);
    assign div_fim  = (div_cnt_q == DC_W'(NUM_W - 1));

    // Restoring step: remainder stays below den, so DEN_W+1 bits hold the shifted value.
    assign rem_desl = {rem_q, num_q[NUM_W-1]};
    assign q_bit    = (rem_desl >= {1'b0, den_q});
    assign rem_prox = q_bit ? DEN_W'(rem_desl - {1'b0, den_q}) : rem_desl[DEN_W-1:0];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            estado_q <= StOcioso;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            StOcioso, StAcumula: begin
                if (aceita) begin
                    estado_d = ultimo ? StDivide : StAcumula;
                end
            end
            StDivide: begin
                if (den_zero || div_fim) begin
                    estado_d = StSaida;
                end
            end
            StSaida:  estado_d = StOcioso;
            default:  estado_d = StOcioso;
        endcase
    end

    always_comb begin
        Pronto      = (estado_q == StOcioso) || (estado_q == StAcumula);
        Ocupado     = (estado_q == StDivide) || (estado_q == StSaida);
        Saida_Valid = (estado_q == StSaida);
        Saida       = saida_q;
        Div_Zero    = div_zero_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            num_q      <= '0;
            den_q      <= '0;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_cnt_q  <= '0;
            saida_q    <= '0;
            div_zero_q <= 1'b0;
        end else begin
            case (estado_q)
                StOcioso, StAcumula: begin
                    rem_q     <= '0;
                    quo_q     <= '0;
                    div_cnt_q <= '0;
                    if (aceita) begin
                        num_q <= ((estado_q == StOcioso) ? '0 : num_q) + prod;
                        den_q <= ((estado_q == StOcioso) ? '0 : den_q) + DEN_W'(soma);
                        cnt_q <= cnt_base + CNT_W'(1);
                    end
                end
                StDivide: begin
                    if (den_zero) begin
                        saida_q    <= '0;
                        div_zero_q <= 1'b1;
                    end else begin
                        num_q     <= num_q << 1;
                        rem_q     <= rem_prox;
                        quo_q     <= {quo_q[W-2:0], q_bit};
                        div_cnt_q <= div_cnt_q + DC_W'(1);
                        if (div_fim) begin
                            saida_q    <= {quo_q[W-2:0], q_bit};
                            div_zero_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bloco_defuzzificador.sv
// Bench for bloco_defuzzificador: directed frames with literal expectations plus random traffic
// checked every cycle against a frame-level arithmetic model.
module tb_bloco_defuzzificador;

    localparam int W      = 8;
    localparam int MAXR   = 16;
    localparam int NUM_W  = 21;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Regra_Valid;
    logic         Regra_Last;
    logic [W-1:0] F_LOW;
    logic [W-1:0] F_UP;
    logic [W-1:0] Centroide;
    logic         Pronto;
    logic [W-1:0] Saida;
    logic         Saida_Valid;
    logic         Div_Zero;
    logic         Ocupado;

    int checks   = 0;
    int failures = 0;

    bloco_defuzzificador dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .Regra_Valid(Regra_Valid),
        .Regra_Last (Regra_Last),
        .F_LOW      (F_LOW),
        .F_UP       (F_UP),
        .Centroide  (Centroide),
        .Pronto     (Pronto),
        .Saida      (Saida),
        .Saida_Valid(Saida_Valid),
        .Div_Zero   (Div_Zero),
        .Ocupado    (Ocupado)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: sums per frame, result = integer quotient, fixed latency in edges.
    longint     m_num   = 0;
    longint     m_den   = 0;
    int         m_cnt   = 0;
    int         m_busy  = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_saida = '0;
    logic       m_dz    = 1'b0;
    logic [7:0] m_res   = '0;
    logic       m_rdz   = 1'b0;

    initial begin
        forever begin
            @(posedge CLK or negedge RESET);
            if (!RESET) begin
                m_num = 0; m_den = 0; m_cnt = 0; m_busy = 0;
                m_valid = 1'b0; m_saida = '0; m_dz = 1'b0;
            end else if (m_valid) begin
                m_valid = 1'b0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_saida = m_res;
                    m_dz    = m_rdz;
                    m_valid = 1'b1;
                end
            end else if (Regra_Valid) begin
                longint s;
                s = longint'(F_LOW) + longint'(F_UP);
                m_num += s * longint'(Centroide);
                m_den += s;
                m_cnt++;
                if (Regra_Last || m_cnt == MAXR) begin
                    if (m_den == 0) begin
                        m_res = '0; m_rdz = 1'b1; m_busy = 1;
                    end else begin
                        m_res = 8'(m_num / m_den); m_rdz = 1'b0; m_busy = NUM_W;
                    end
                    m_num = 0; m_den = 0; m_cnt = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            check("pronto",      32'(Pronto),      32'(m_busy == 0 && !m_valid));
            check("ocupado",     32'(Ocupado),     32'(m_busy != 0 || m_valid));
            check("saida_valid", 32'(Saida_Valid), 32'(m_valid));
            check("saida",       32'(Saida),       32'(m_saida));
            check("div_zero",    32'(Div_Zero),    32'(m_dz));
        end
    end

    task automatic beat(input int lo, input int up, input int c, input bit last);
        int k;
        Regra_Valid = 1'b1;
        Regra_Last  = last;
        F_LOW       = 8'(lo);
        F_UP        = 8'(up);
        Centroide   = 8'(c);
        k = 0;
        while (!Pronto && k < 200) begin
            @(posedge CLK); #1;
            k++;
        end
        if (k >= 200) begin
            checks++; failures++;
            $display("FAIL beat_wait: Pronto stayed low for %0d cycles, required high", k);
        end
        @(posedge CLK); #1;
        Regra_Valid = 1'b0;
        Regra_Last  = 1'b0;
    endtask

    task automatic wait_result(input string name, input int exp_s, input bit exp_dz,
                               input int exp_lat);
        int k;
        k = 0;
        while (!Saida_Valid && k < 100) begin
            @(posedge CLK); #1;
            k++;
        end
        check({name, "_latency"}, 32'(k), 32'(exp_lat));
        check({name, "_saida"}, 32'(Saida), 32'(exp_s));
        check({name, "_div_zero"}, 32'(Div_Zero), 32'(exp_dz));
        check({name, "_model"}, 32'(m_saida), 32'(exp_s));
        @(posedge CLK); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b0; Regra_Valid = 1'b0; Regra_Last = 1'b0;
        F_LOW = '0; F_UP = '0; Centroide = '0;
        #1;
        check("reset_pronto", 32'(Pronto), 32'd1);
        check("reset_saida", 32'(Saida), 32'd0);
        check("reset_ocupado", 32'(Ocupado), 32'd0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;

        beat(100, 200, 77, 1'b1);
        check("single_pronto_low", 32'(Pronto), 32'd0);
        wait_result("single", 77, 1'b0, NUM_W);

        beat(0, 255, 0, 1'b0);
        beat(0, 255, 255, 1'b1);
        wait_result("two", 127, 1'b0, NUM_W);

        for (int i = 1; i <= 9; i++) beat(255, 255, 10 * i, i == 9);
        wait_result("nine", 50, 1'b0, NUM_W);

        for (int i = 0; i < 3; i++) beat(0, 0, 200, i == 2);
        wait_result("zero", 0, 1'b1, 1);
        beat(50, 50, 30, 1'b1);
        wait_result("after_zero", 30, 1'b0, NUM_W);

        for (int i = 0; i < 16; i++) beat(255, 255, 255, 1'b0);
        Regra_Valid = 1'b1; F_LOW = 8'd1; F_UP = 8'd1; Centroide = 8'd1;
        repeat (12) begin @(posedge CLK); #1; end
        Regra_Valid = 1'b0;
        wait_result("forced", 255, 1'b0, NUM_W - 12);

        beat(100, 100, 50, 1'b1);
        repeat (10) begin @(posedge CLK); #1; end
        #2 RESET = 1'b0;
        #1;
        check("mid_reset_saida", 32'(Saida), 32'd0);
        check("mid_reset_valid", 32'(Saida_Valid), 32'd0);
        check("mid_reset_div_zero", 32'(Div_Zero), 32'd0);
        check("mid_reset_ocupado", 32'(Ocupado), 32'd0);
        check("mid_reset_pronto", 32'(Pronto), 32'd1);
        @(posedge CLK); #1 RESET = 1'b1;
        beat(10, 20, 5, 1'b1);
        wait_result("post_reset", 5, 1'b0, NUM_W);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge CLK); #1;
            RESET       = ($urandom % 400) != 0;
            Regra_Valid = ($urandom % 3) != 0;
            Regra_Last  = ($urandom % 6) == 0;
            F_LOW       = (($urandom % 5) == 0) ? 8'd0 : 8'($urandom);
            F_UP        = (($urandom % 5) == 0) ? 8'd0 : 8'($urandom);
            Centroide   = 8'($urandom);
            if (($urandom % 10) == 0) begin
                F_LOW = '0; F_UP = '0;
            end
        end
        @(posedge CLK); #1;
        RESET = 1'b1; Regra_Valid = 1'b0;
        repeat (30) @(posedge CLK);
        @(negedge CLK); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bloco_defuzzificador.md
# bloco_defuzzificador

Type-reduction and defuzzification stage of the interval type-2 fuzzy controller: the output end of the chain whose input end is the fuzzifier. It accepts a serial stream of rule firing intervals (lower/upper strength) with each rule's consequent centroid. It computes the crisp output with the Nie-Tan average, y = Σ((F_LOW+F_UP)·C) / Σ(F_LOW+F_UP), using a multi-cycle restoring divider. It sits between the inference (rule/t-norm) block and the plant actuator interface.

## Interface
- W, 8: width of firing strengths, centroids and output
- MAX_REGRAS, 16: maximum rules per frame (power of two)
- NUM_W, 2*W+1+log2(MAX_REGRAS) = 21: numerator accumulator width; also number of divide cycles
- DEN_W, W+1+log2(MAX_REGRAS) = 13: denominator accumulator width

- CLK  input  1  single clock, rising edge
- RESET  input  1  asynchronous, active-low reset
- Regra_Valid  input  1  rule beat present
- Regra_Last  input  1  current beat is last rule of frame
- F_LOW  input  W  lower firing strength
- F_UP  input  W  upper firing strength
- Centroide  input  W  consequent centroid of the rule
- Pronto  output  1  block accepts a beat this cycle
- Saida  output  W  crisp output, held until next result
- Saida_Valid  output  1  one-cycle pulse: new Saida
- Div_Zero  output  1  last frame had zero total firing, held with Saida
- Ocupado  output  1  high in DIVIDE and SAIDA

## Operation
- States: OCIOSO, ACUMULA, DIVIDE, SAIDA.
- Beat accepted on rising edge where Regra_Valid && Pronto. Pronto = 1 in OCIOSO and ACUMULA, 0 otherwise. Regra_Valid while Pronto=0 is ignored.
- Per beat: s = F_LOW + F_UP (W+1 bits, no overflow). num += s·Centroide; den += s; cnt += 1.
- First beat accepted in OCIOSO loads num/den/cnt with that beat's terms; stale frame values are discarded.
- OCIOSO → ACUMULA on accepted non-last beat. OCIOSO/ACUMULA → DIVIDE on accepted beat with Regra_Last=1 or on the MAX_REGRAS-th beat (forced last).
- DIVIDE: if den==0 → SAIDA after 1 cycle with Saida=0, Div_Zero=1. Otherwise restoring division, one quotient bit per cycle MSB-first, NUM_W cycles; Saida = floor(num/den) (fits W bits because the result is a weighted mean of centroids), Div_Zero=0.
- SAIDA: Saida_Valid=1 for exactly one cycle, → OCIOSO.
- Saida/Div_Zero update only on the DIVIDE→SAIDA edge.
- RESET low at any time (incl. mid-DIVIDE): state OCIOSO; Saida=0, Saida_Valid=0, Div_Zero=0, Ocupado=0, Pronto=1; num/den/cnt/quotient cleared; partial result lost.

## Timing
- Reset values: Pronto=1, Saida=0, Saida_Valid=0, Div_Zero=0, Ocupado=0.
- Throughput: one beat per cycle during accumulation.
- Edge E0 accepts last beat. Edges E1..E21 (NUM_W) divide. Saida/Saida_Valid are registered at E21 and visible E21→E22. Pronto returns at E22.
- den==0: Saida_Valid visible E1→E2; Pronto returns at E2.
- Frame spacing minimum: NUM_W+2 cycles after last beat before next first beat.
- Pronto is registered (state-decoded); the beat at E0 is accepted; the cycle after E0 has Pronto=0.
- All outputs registered; no combinational input→output path.

## Test plan
- Single rule F_LOW=100, F_UP=200, C=77, Last=1 → Saida=77, Div_Zero=0, Saida_Valid pulse 21 edges after E0, Pronto low in between.
- Two rules (0,255,C=0),(0,255,C=255) → num=65025, den=510 → Saida=127.
- Nine rules F_LOW=F_UP=255, C=10,20..90 back-to-back, Valid every cycle → num=229500, den=4590 → Saida=50; verify no beat dropped.
- Three rules all F=0, C=200 → Saida=0, Div_Zero=1, Saida_Valid 1 cycle after E0. Next frame (50,50,C=30) → Saida=30, Div_Zero=0.
- Sixteen rules F=255/255, C=255, Last never asserted → forced last at beat 16, num=2080800 (no overflow), Saida=255. A 17th Valid held during DIVIDE is ignored.
- RESET low during DIVIDE cycle 10 → all outputs to reset values immediately; no Saida_Valid. After release, frame (10,20,C=5) → Saida=5.
